// File: rtl/game_ctrl.sv
// game_ctrl: round/game sequencer that arms, serves, scores bar hits and spends lives.
// All outputs decode from the registered state one clock after the deciding edge; no backpressure, inputs are levels.
module game_ctrl #(
  parameter int LIVES          = 3,
  parameter int HITS_PER_LEVEL = 4,
  parameter int MAX_LEVEL      = 7,
  parameter int SERVE_DELAY    = 25_000_000,
  parameter int CLR_CYCLES     = 2,
  parameter int SCORE_MAX      = 999
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       endgame,
  input  logic       hit_bar,
  output logic       ball_run,
  output logic [1:0] lives,
  output logic [9:0] score,
  output logic [2:0] speed_level,
  output logic       game_over,
  output logic [2:0] state_leds
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    PLAY = 3'd2,
    LOST = 3'd3,
    OVER = 3'd4
  } state_t;

  localparam int DW = $clog2(SERVE_DELAY + 1);
  localparam int CW = $clog2(CLR_CYCLES + 1);
  localparam int HW = $clog2(HITS_PER_LEVEL + 1);

  localparam logic [DW-1:0] DLY_LAST   = DW'(SERVE_DELAY - 1);
  localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_CYCLES - 1);
  localparam logic [HW-1:0] HIT_LAST   = HW'(HITS_PER_LEVEL - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(LIVES);
  localparam logic [9:0]    SCORE_TOP  = 10'(SCORE_MAX);
  localparam logic [2:0]    LEVEL_TOP  = 3'(MAX_LEVEL);

  state_t        state, state_d;
  logic [1:0]    lives_d;
  logic [9:0]    score_d;
  logic [2:0]    level_d;
  logic [HW-1:0] hit_cnt, hit_cnt_d;
  logic [DW-1:0] dly_cnt, dly_cnt_d;
  logic [CW-1:0] clr_cnt, clr_cnt_d;
  logic          start_q, hit_q;
  logic          start_rise, hit_rise;

  assign start_rise = btn_start & ~start_q;
  assign hit_rise   = hit_bar & ~hit_q;

  always_comb begin
    state_d   = state;
    lives_d   = lives;
    score_d   = score;
    level_d   = speed_level;
    hit_cnt_d = hit_cnt;
    dly_cnt_d = '0;
    clr_cnt_d = '0;
    case (state)
      IDLE: begin
        if (start_rise) state_d = ARM;
      end
      ARM: begin
        if (dly_cnt == DLY_LAST) state_d = PLAY;
        else                     dly_cnt_d = dly_cnt + 1'b1;
      end
      PLAY: begin
        // losing the ball takes priority over a simultaneous bar contact
        if (endgame) begin
          state_d = LOST;
        end else if (hit_rise) begin
          score_d = (score >= SCORE_TOP) ? SCORE_TOP : score + 1'b1;
          if (hit_cnt == HIT_LAST) begin
            hit_cnt_d = '0;
            level_d   = (speed_level >= LEVEL_TOP) ? LEVEL_TOP : speed_level + 1'b1;
          end else begin
            hit_cnt_d = hit_cnt + 1'b1;
          end
        end
      end
      LOST: begin
        if (clr_cnt == CLR_LAST) begin
          hit_cnt_d = '0;
          lives_d   = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
          state_d   = (lives <= 2'd1) ? OVER : IDLE;
        end else begin
          clr_cnt_d = clr_cnt + 1'b1;
        end
      end
      OVER: begin
        lives_d = 2'd0;
        if (start_rise) begin
          state_d   = ARM;
          lives_d   = LIVES_INIT;
          score_d   = '0;
          level_d   = '0;
          hit_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      lives       <= LIVES_INIT;
      score       <= '0;
      speed_level <= '0;
      hit_cnt     <= '0;
      dly_cnt     <= '0;
      clr_cnt     <= '0;
      start_q     <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      state       <= state_d;
      lives       <= lives_d;
      score       <= score_d;
      speed_level <= level_d;
      hit_cnt     <= hit_cnt_d;
      dly_cnt     <= dly_cnt_d;
      clr_cnt     <= clr_cnt_d;
      start_q     <= btn_start;
      hit_q       <= hit_bar;
    end
  end

  assign ball_run   = (state == PLAY);
  assign game_over  = (state == OVER);
  assign state_leds = state;

endmodule
